hazard_issue_queue: RTL
=======================

Name: hazard_issue_queue

Overview:
- Parametrised N-channel successor to the dual-pipe dependency resolver; sits between decode and register read/execute.
- Per-channel FIFO absorbs decoded instructions. A shared register scoreboard holds any head instruction whose source register is still in flight (RAW).
- Adds an explicit full/hazard split, true occupancy tracking, intra-bundle cross-channel hazard detection, and configurable depth, channel count and register count.

Parameters:
- NUM_CH, 2, number of issue channels
- DEPTH, 8, entries per channel FIFO (power of two, >=2)
- NUM_REGS, 32, scoreboard entries
- REG_W, 5, register address width (2**REG_W == NUM_REGS)
- OPC_W, 7, opcode width
- SEC_W, 16, secondary operand width (low REG_W bits are the register address)
- STALL_DELAY, 8, cycles a destination register is blocked after issue (1..15)

Ports:
- clock_i  in  1  clock
- reset_i  in  1  asynchronous, active-low reset
- enable_i  in  NUM_CH  per-channel push request
- pwrite_i / pread_i / sread_i  in  NUM_CH each  primary-write, primary-read, secondary-read flags
- func_type_i  in  2*NUM_CH  function type, channel c at [2c+:2]
- opcode_i  in  OPC_W*NUM_CH  opcodes
- prim_operand_i  in  REG_W*NUM_CH  primary register
- sec_operand_i  in  SEC_W*NUM_CH  secondary operand
- should_stall_i  in  1  downstream stall; freezes issue
- full_o  out  NUM_CH  channel FIFO full, combinational from count
- hazard_o  out  NUM_CH  registered; head held by RAW this cycle
- count_o  out  NUM_CH*($clog2(DEPTH)+1)  per-channel occupancy
- enable_o, pwrite_o, pread_o, sread_o, func_type_o, opcode_o, prim_operand_o, sec_operand_o  out  same widths as inputs  registered issue outputs

Behaviour:
- Reset (reset_i=0, async):
  - all FIFO pointers and counts = 0; all scoreboard counters = 0.
  - all outputs = 0; full_o=0.
- Push:
  - channel c accepts when enable_i[c] && !full_o[c]; the write pointer increments modulo DEPTH.
  - a push while full is dropped; the upstream must hold the instruction while full_o[c]=1.
- Head ready: count[c]>0 and no blocking source. Blocking sources are:
  - pread && sb[prim]!=0
  - sread && sb[sec[REG_W-1:0]]!=0
  - intra-bundle: a lower-index channel k<c issuing this cycle with pwrite whose prim matches an enabled source of c.
- Issue, when should_stall_i=0:
  - each ready channel registers its head onto the outputs, with enable_o[c]=1 if the stored enable was 1, and pops.
  - each non-ready channel drives enable_o[c]=0. hazard_o[c]=1 iff count>0 and blocked.
- should_stall_i=1: no pop; all outputs, including enable_o and hazard_o, hold their previous values. Pushes still occur.
- Latency: an instruction pushed at edge N is earliest on the outputs after edge N+1. There is no empty-queue bypass.
- Push and pop on the same channel in the same cycle: count unchanged, both pointers advance. When full, the push is refused even if a pop occurs (full_o uses the registered count).
- Scoreboard:
  - each nonzero counter decrements by 1 per cycle.
  - an issuing pwrite sets sb[prim]=STALL_DELAY; the set wins over the decrement.
  - multiple channels writing the same register in one cycle all set STALL_DELAY.
  - counter width = $clog2(STALL_DELAY+1).
  - decrement continues during should_stall_i.
- Pointer wrap: indices are DEPTH-modulo natural wrap. count distinguishes full from empty; the pointers are never compared for this.

Optional Feature:
- Macro HDR_WB_RELEASE_EN.
- Defined: adds ports wb_valid_i (in, NUM_CH) and wb_reg_i (in, REG_W*NUM_CH). A writeback clears sb[wb_reg] to 0 at the next edge.
  - a clear loses to an issue-set on the same register in the same cycle.
  - a clear wins over the decrement.
- Undefined: ports absent; registers release only by countdown.

Decomposition:
- Package hdr_pkg holds:
  - default widths (REG_W, OPC_W, SEC_W);
  - the packed instruction-entry typedef {enable, pwrite, pread, sread, func_type, opcode, prim, sec};
  - the STALL_DELAY default.
- Sub-module hdr_channel_fifo: one DEPTH-entry FIFO exposing head, count, push and pop. It is instantiated NUM_CH times.
- Scoreboard and issue arbitration stay in the top level.

Test Plan:
- Reset mid-traffic: push 3 on ch0, drop reset_i low → count_o=0, enable_o=0 and sb cleared immediately (async). First push after release appears on the outputs 1 cycle later.
- RAW single channel: ch0 issues pwrite r5, then pread r5 → second instruction holds hazard_o[0]=1 for 8 cycles, then issues.
- Intra-bundle: same cycle ch0 pwrite r3, ch1 pread r3 → ch0 issues, ch1 enable_o=0, then held 8 further cycles. Same pattern to r4 on ch1 → no hold.
- Full: push 9 consecutive on ch1 with should_stall_i=1 → full_o[1]=1 after 8, 9th dropped, count_o=8. Release → 8 issue in order, wrap correct.
- Stall hold: should_stall_i=1 for 5 cycles after a valid issue → outputs unchanged, count unchanged, sb counter drops 8→3.
- HDR_WB_RELEASE_EN: pwrite r7 then wb_valid_i with r7 two cycles later → dependent pread r7 issues on the cycle after the clear. Without the macro it waits the full 8 cycles.

Source files
------------

// File: rtl/hdr_pkg.sv
`default_nettype none
// ============================================================================
// hdr_pkg : shared widths, entry layout and defaults for hazard_issue_queue
// Rev 1.0
// ============================================================================
package hdr_pkg;

  localparam int DEF_REG_W       = 5;
  localparam int DEF_OPC_W       = 7;
  localparam int DEF_SEC_W       = 16;
  localparam int DEF_STALL_DELAY = 8;

  // Field order, MSB first, matches the packing used for every FIFO entry
  typedef struct packed {
    logic                 enable;
    logic                 pwrite;
    logic                 pread;
    logic                 sread;
    logic [1:0]           func_type;
    logic [DEF_OPC_W-1:0] opcode;
    logic [DEF_REG_W-1:0] prim;
    logic [DEF_SEC_W-1:0] sec;
  } hdr_entry_t;

  localparam int DEF_ENTRY_W = $bits(hdr_entry_t);

  function automatic int entry_width(input int opc_w, input int reg_w, input int sec_w);
    return 6 + opc_w + reg_w + sec_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hdr_channel_fifo.sv
`default_nettype none
// ============================================================================
// hdr_channel_fifo : DEPTH-entry per-channel instruction FIFO with occupancy
// Rev 1.0
// ============================================================================
module hdr_channel_fifo
  import hdr_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = DEF_ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  // Full comes from the registered count, so a same-cycle pop never frees a slot
  assign full_o  = (count_q == FULL_CNT);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_issue_queue.sv
`default_nettype none
// ============================================================================
// hazard_issue_queue : N-channel issue queue with shared RAW scoreboard and
// intra-bundle hazard detection. Optional writeback release: HDR_WB_RELEASE_EN
// Rev 1.0
// ============================================================================
module hazard_issue_queue
  import hdr_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DEPTH       = 8,
  parameter int NUM_REGS    = 32,
  parameter int REG_W       = DEF_REG_W,
  parameter int OPC_W       = DEF_OPC_W,
  parameter int SEC_W       = DEF_SEC_W,
  parameter int STALL_DELAY = DEF_STALL_DELAY
) (
  input  logic                              clock_i,
  input  logic                              reset_i,
  input  logic [NUM_CH-1:0]                 enable_i,
  input  logic [NUM_CH-1:0]                 pwrite_i,
  input  logic [NUM_CH-1:0]                 pread_i,
  input  logic [NUM_CH-1:0]                 sread_i,
  input  logic [2*NUM_CH-1:0]               func_type_i,
  input  logic [OPC_W*NUM_CH-1:0]           opcode_i,
  input  logic [REG_W*NUM_CH-1:0]           prim_operand_i,
  input  logic [SEC_W*NUM_CH-1:0]           sec_operand_i,
`ifdef HDR_WB_RELEASE_EN
  input  logic [NUM_CH-1:0]                 wb_valid_i,
  input  logic [REG_W*NUM_CH-1:0]           wb_reg_i,
`endif
  input  logic                              should_stall_i,
  output logic [NUM_CH-1:0]                 full_o,
  output logic [NUM_CH-1:0]                 hazard_o,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0] count_o,
  output logic [NUM_CH-1:0]                 enable_o,
  output logic [NUM_CH-1:0]                 pwrite_o,
  output logic [NUM_CH-1:0]                 pread_o,
  output logic [NUM_CH-1:0]                 sread_o,
  output logic [2*NUM_CH-1:0]               func_type_o,
  output logic [OPC_W*NUM_CH-1:0]           opcode_o,
  output logic [REG_W*NUM_CH-1:0]           prim_operand_o,
  output logic [SEC_W*NUM_CH-1:0]           sec_operand_o
);

  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int SB_W     = $clog2(STALL_DELAY + 1);
  localparam int EW       = entry_width(OPC_W, REG_W, SEC_W);
  localparam int PRIM_LSB = SEC_W;
  localparam int OPC_LSB  = SEC_W + REG_W;
  localparam int FT_LSB   = OPC_LSB + OPC_W;
  localparam int SR_B     = FT_LSB + 2;
  localparam int PR_B     = SR_B + 1;
  localparam int PW_B     = PR_B + 1;
  localparam int EN_B     = PW_B + 1;
  localparam logic [SB_W-1:0] SB_SET = SB_W'(STALL_DELAY);

  logic [EW-1:0]     head    [NUM_CH];
  logic [EW-1:0]     issue_q [NUM_CH];
  logic [EW-1:0]     issue_d [NUM_CH];
  logic [REG_W-1:0]  h_prim  [NUM_CH];
  logic [REG_W-1:0]  h_src2  [NUM_CH];
  logic [SB_W-1:0]   sb_q    [NUM_REGS];
  logic [SB_W-1:0]   sb_d    [NUM_REGS];
  logic [NUM_CH-1:0] hazard_q, hazard_d;
  logic [NUM_CH-1:0] has_data, blocked, ready, pop;
  logic [NUM_CH-1:0] h_pwrite, h_pread, h_sread;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [CW-1:0] cnt;

      hdr_channel_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
      ) u_fifo (
        .clk     (clock_i),
        .rst_n   (reset_i),
        .push_i  (enable_i[c]),
        .pop_i   (pop[c]),
        .din_i   ({enable_i[c], pwrite_i[c], pread_i[c], sread_i[c],
                   func_type_i[2*c +: 2], opcode_i[OPC_W*c +: OPC_W],
                   prim_operand_i[REG_W*c +: REG_W], sec_operand_i[SEC_W*c +: SEC_W]}),
        .head_o  (head[c]),
        .count_o (cnt),
        .full_o  (full_o[c])
      );

      assign count_o[CW*c +: CW] = cnt;
      assign has_data[c] = (cnt != '0);
      assign h_pwrite[c] = head[c][PW_B];
      assign h_pread[c]  = head[c][PR_B];
      assign h_sread[c]  = head[c][SR_B];
      assign h_prim[c]   = head[c][PRIM_LSB +: REG_W];
      assign h_src2[c]   = head[c][REG_W-1:0];

      assign enable_o[c]                      = issue_q[c][EN_B];
      assign pwrite_o[c]                      = issue_q[c][PW_B];
      assign pread_o[c]                       = issue_q[c][PR_B];
      assign sread_o[c]                       = issue_q[c][SR_B];
      assign func_type_o[2*c +: 2]            = issue_q[c][FT_LSB +: 2];
      assign opcode_o[OPC_W*c +: OPC_W]       = issue_q[c][OPC_LSB +: OPC_W];
      assign prim_operand_o[REG_W*c +: REG_W] = issue_q[c][PRIM_LSB +: REG_W];
      assign sec_operand_o[SEC_W*c +: SEC_W]  = issue_q[c][SEC_W-1:0];
    end
  endgenerate

  assign hazard_o = hazard_q;

  // Channels resolve in index order so a lower channel's issue decision is
  // known when checking the higher channels of the same bundle.
  always_comb begin
    blocked = '0;
    ready   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (h_pread[c] && (sb_q[h_prim[c]] != '0)) blocked[c] = 1'b1;
      if (h_sread[c] && (sb_q[h_src2[c]] != '0)) blocked[c] = 1'b1;
      for (int k = 0; k < c; k++) begin
        if (ready[k] && h_pwrite[k] &&
            ((h_pread[c] && (h_prim[k] == h_prim[c])) ||
             (h_sread[c] && (h_prim[k] == h_src2[c])))) begin
          blocked[c] = 1'b1;
        end
      end
      ready[c] = has_data[c] && !blocked[c];
    end
  end

  always_comb begin
    issue_d  = issue_q;
    hazard_d = hazard_q;
    pop      = '0;
    if (!should_stall_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        pop[c]      = ready[c];
        hazard_d[c] = has_data[c] && blocked[c];
        issue_d[c]  = ready[c] ? head[c] : '0;
      end
    end
  end

  // Priority, lowest to highest: countdown, writeback clear, issue set
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      sb_d[r] = (sb_q[r] != '0) ? (sb_q[r] - 1'b1) : '0;
    end
`ifdef HDR_WB_RELEASE_EN
    for (int c = 0; c < NUM_CH; c++) begin
      if (wb_valid_i[c]) sb_d[wb_reg_i[REG_W*c +: REG_W]] = '0;
    end
`endif
    if (!should_stall_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ready[c] && h_pwrite[c]) sb_d[h_prim[c]] = SB_SET;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      issue_q  <= '{default: '0};
      hazard_q <= '0;
      sb_q     <= '{default: '0};
    end else begin
      issue_q  <= issue_d;
      hazard_q <= hazard_d;
      sb_q     <= sb_d;
    end
  end

endmodule
`default_nettype wire
